// File: rtl/vga_palette_lut.sv
// vga_palette_lut: writable colour palette with blink attribute, blanking and 2-cycle matched sync delay.
module vga_palette_lut #(
  parameter int IDX_W        = 3,
  parameter int CH_W         = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_addr,
  input  logic [3*CH_W:0]   pal_wdata,
  input  logic [IDX_W-1:0]  pal_raddr,
  output logic [3*CH_W:0]   pal_rdata,
  input  logic              frame_tick,
  input  logic              pix_valid,
  input  logic [IDX_W-1:0]  pix_idx,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [CH_W-1:0]   R,
  output logic [CH_W-1:0]   G,
  output logic [CH_W-1:0]   B,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              pix_valid_out
);
  localparam int DW    = 3*CH_W+1;
  localparam int DEPTH = 2**IDX_W;
  localparam int CW    = $clog2(BLINK_FRAMES)+1;
  localparam logic [11:0] RST_TAB [8] = '{12'h111, 12'h555, 12'h000, 12'h100,
                                          12'h111, 12'h001, 12'h010, 12'h600};

  function automatic logic [DW-1:0] rst_entry(input int i);
    logic [11:0] n;
    n = (i < 8) ? RST_TAB[i[2:0]] : 12'h0;
    return {1'b0, CH_W'(n[11:8]), CH_W'(n[7:4]), CH_W'(n[3:0])};
  endfunction

  logic [DW-1:0]     pal_q [DEPTH];
  logic [DW-1:0]     pal_d [DEPTH];
  logic [DW-1:0]     rdata_q, rdata_d, entry, sel;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              phase_q, phase_d, wrap;
  logic [IDX_W-1:0]  idx_s1_q;
  logic              valid_s1_q, hs_s1_q, vs_s1_q;
  logic [3*CH_W-1:0] rgb_q, rgb_d;
  logic              valid_s2_q, hs_s2_q, vs_s2_q;

  always_comb begin
    pal_d = pal_q;
    if (pal_we) pal_d[pal_addr] = pal_wdata;
    rdata_d = pal_q[pal_raddr];
    wrap    = frame_tick && (cnt_q == CW'(BLINK_FRAMES-1));
    cnt_d   = !frame_tick ? cnt_q : wrap ? '0 : cnt_q + CW'(1);
    phase_d = phase_q ^ wrap;
    // S1 index reads the palette after any write in its own cycle, giving write-first pixels
    entry   = pal_q[idx_s1_q];
    sel     = (entry[DW-1] && phase_q) ? pal_q[0] : entry;
    rgb_d   = valid_s1_q ? sel[DW-2:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pal_q[i] <= rst_entry(i);
      rdata_q    <= '0;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      idx_s1_q   <= '0;
      valid_s1_q <= 1'b0;
      hs_s1_q    <= 1'b1;
      vs_s1_q    <= 1'b1;
      rgb_q      <= '0;
      valid_s2_q <= 1'b0;
      hs_s2_q    <= 1'b1;
      vs_s2_q    <= 1'b1;
    end else begin
      pal_q      <= pal_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      idx_s1_q   <= pix_idx;
      valid_s1_q <= pix_valid;
      hs_s1_q    <= hsync_in;
      vs_s1_q    <= vsync_in;
      rgb_q      <= rgb_d;
      valid_s2_q <= valid_s1_q;
      hs_s2_q    <= hs_s1_q;
      vs_s2_q    <= vs_s1_q;
    end

  assign pal_rdata     = rdata_q;
  assign {R, G, B}     = rgb_q;
  assign hsync_out     = hs_s2_q;
  assign vsync_out     = vs_s2_q;
  assign pix_valid_out = valid_s2_q;
endmodule

// File: tb/tb_vga_palette_lut.sv
// tb_vga_palette_lut: scoreboard bench driving two palettes (BLINK_FRAMES=2 and =1) with shared stimulus.
module tb_vga_palette_lut;
  logic        clk = 0, rst_n = 0, pal_we = 0, frame_tick = 0, pix_valid = 0, hs = 1, vs = 1;
  logic [2:0]  pal_addr = 0, pal_raddr = 0, pix_idx = 0;
  logic [12:0] pal_wdata = 0;
  logic [12:0] rd_a, rd_b;
  logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hso_a, vso_a, pvo_a, hso_b, vso_b, pvo_b;

  vga_palette_lut #(.IDX_W(3), .CH_W(4), .BLINK_FRAMES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .pal_raddr(pal_raddr), .pal_rdata(rd_a), .frame_tick(frame_tick), .pix_valid(pix_valid),
    .pix_idx(pix_idx), .hsync_in(hs), .vsync_in(vs), .R(r_a), .G(g_a), .B(b_a),
    .hsync_out(hso_a), .vsync_out(vso_a), .pix_valid_out(pvo_a));

  vga_palette_lut #(.IDX_W(3), .CH_W(4), .BLINK_FRAMES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .pal_raddr(pal_raddr), .pal_rdata(rd_b), .frame_tick(frame_tick), .pix_valid(pix_valid),
    .pix_idx(pix_idx), .hsync_in(hs), .vsync_in(vs), .R(r_b), .G(g_b), .B(b_b),
    .hsync_out(hso_b), .vsync_out(vso_b), .pix_valid_out(pvo_b));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [12:0] m_pal [8];
  int          cnt_a;
  bit          ph_a, ph_b;
  logic [14:0] q_a [$], q_b [$];
  logic [12:0] q_rd [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [12:0] rst_val(input int i);
    logic [11:0] t [8];
    t = '{12'h111, 12'h555, 12'h000, 12'h100, 12'h111, 12'h001, 12'h010, 12'h600};
    return {1'b0, t[i]};
  endfunction

  function automatic logic [14:0] exp_pix(input bit ph);
    logic [12:0] e, s;
    e = m_pal[pix_idx];
    s = (e[12] && ph) ? m_pal[0] : e;
    return {pix_valid, hs, vs, pix_valid ? s[11:0] : 12'h0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pal[i] = rst_val(i);
    cnt_a = 0; ph_a = 0; ph_b = 0;
    q_a.delete(); q_b.delete(); q_rd.delete();
  endtask

  task automatic cycle(input bit we, input logic [2:0] addr, input logic [12:0] wd,
                       input logic [2:0] ra, input bit tick, input bit v,
                       input logic [2:0] idx, input bit h, input bit vv);
    logic [14:0] e;
    logic [12:0] er;
    @(negedge clk);
    if (q_a.size() == 2) begin
      e = q_a.pop_front(); check("pix_a", {pvo_a, hso_a, vso_a, r_a, g_a, b_a}, e);
      e = q_b.pop_front(); check("pix_b", {pvo_b, hso_b, vso_b, r_b, g_b, b_b}, e);
    end
    if (q_rd.size() == 1) begin
      er = q_rd.pop_front();
      check("rdata_a", rd_a, er);
      check("rdata_b", rd_b, er);
    end
    pal_we = we; pal_addr = addr; pal_wdata = wd; pal_raddr = ra; frame_tick = tick;
    pix_valid = v; pix_idx = idx; hs = h; vs = vv;
    q_rd.push_back(m_pal[ra]);
    if (we) m_pal[addr] = wd;
    if (tick) begin
      if (cnt_a == 1) begin cnt_a = 0; ph_a = ~ph_a; end else cnt_a++;
      ph_b = ~ph_b;
    end
    q_a.push_back(exp_pix(ph_a));
    q_b.push_back(exp_pix(ph_b));
  endtask

  task automatic pix(input logic [2:0] idx, input bit tick);
    cycle(0, 0, 0, idx, tick, 1, idx, 1, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pal_we = 0; frame_tick = 0;
    #2 rst_n = 0;
    #1;
    check("rst_rgb_a", {r_a, g_a, b_a}, 0);
    check("rst_flags_a", {pvo_a, hso_a, vso_a}, 3'b011);
    check("rst_rgb_b", {r_b, g_b, b_b}, 0);
    check("rst_flags_b", {pvo_b, hso_b, vso_b}, 3'b011);
    check("rst_rdata", rd_a, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();
    for (int i = 0; i < 8; i++) pix(3'(i), 0);
    for (int k = 0; k < 6; k++)
      cycle(0, 0, 0, 1, 0, 0, 1, !(k >= 1 && k <= 3), !(k >= 1 && k <= 3));
    cycle(1, 5, 13'h0FA3, 0, 0, 1, 5, 1, 1);
    pix(5, 0);
    cycle(1, 3, 13'h1100, 3, 0, 1, 3, 1, 1);
    pix(3, 0);
    pix(3, 1);
    pix(3, 1);
    for (int k = 0; k < 3; k++) pix(3, 0);
    pix(3, 1);
    pix(3, 1);
    for (int k = 0; k < 3; k++) pix(3, 0);
    cycle(1, 0, 13'h1222, 0, 0, 1, 0, 1, 1);
    pix(0, 1);
    pix(0, 1);
    pix(0, 0);
    cycle(1, 7, 13'h0ABC, 7, 0, 1, 7, 1, 1);
    pix(7, 0);
    pix(7, 0);
    do_reset();
    pix(7, 0);
    pix(7, 0);
    cycle(1, 3, 13'h1100, 3, 0, 1, 3, 1, 1);
    for (int k = 0; k < 10; k++) pix((k % 2) ? 3'd4 : 3'd3, 1);
    for (int k = 0; k < 6; k++) pix(3, 1);
    for (int k = 0; k < 40; k++)
      cycle(($urandom_range(0, 3) == 0), 3'($urandom), 13'($urandom), 3'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 3'($urandom),
            $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
